// File: rtl/apb4_slave_mem_if.sv
// APB4 bus bundle between a requester (master modport) and a completer (slave modport).
// Handshake: a transfer starts with a setup cycle (PSEL=1, PENABLE=0) and completes on the
// rising edge where PSEL=1, PENABLE=1 and PREADY=1; PSLVERR and PRDATA are only meaningful then.
interface apb4_slave_mem_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    PSEL;
  logic                    PENABLE;
  logic                    PWRITE;
  logic [ADDR_WIDTH-1:0]   PADDR;
  logic [DATA_WIDTH-1:0]   PWDATA;
  logic [DATA_WIDTH/8-1:0] PSTRB;
  logic [DATA_WIDTH-1:0]   PRDATA;
  logic                    PREADY;
  logic                    PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb4_slave_mem.sv
// APB4 completer: DEPTH-word memory with byte strobes, fixed wait states and
// PSLVERR on misaligned or out-of-range addresses.
module apb4_slave_mem #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  apb4_slave_mem_if.slave  bus,
  output logic [0:0]       dbg_state
);
  localparam int SW = DATA_WIDTH / 8;
  localparam int AL = $clog2(SW);
  localparam int IW = $clog2(DEPTH);
  localparam int WW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(SW - 1);
  localparam logic [ADDR_WIDTH-1:0] SPAN       = ADDR_WIDTH'(DEPTH * SW);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;

  logic [0:0]            state;
  logic                  write_q;
  logic                  err_q;
  logic [IW-1:0]         index_q;
  logic [SW-1:0]         strb_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] prdata_q;
  logic [WW-1:0]         wcnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic          setup;
  logic          err_in;
  logic [IW-1:0] index_in;
  logic          ready;

  assign setup    = bus.PSEL & ~bus.PENABLE;
  assign index_in = bus.PADDR[AL +: IW];
  assign err_in   = (|(bus.PADDR & ALIGN_MASK)) | (bus.PADDR >= SPAN);
  assign ready    = (state == ACCESS) && (wcnt == '0);

  assign bus.PREADY  = ready;
  assign bus.PSLVERR = err_q & ready;
  assign bus.PRDATA  = prdata_q;
  assign dbg_state   = state;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state    <= IDLE;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
      index_q  <= '0;
      strb_q   <= '0;
      wdata_q  <= '0;
      prdata_q <= '0;
      wcnt     <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (setup) begin
      // A setup seen in ACCESS restarts the transfer with freshly latched fields.
      state    <= ACCESS;
      write_q  <= bus.PWRITE;
      err_q    <= err_in;
      index_q  <= index_in;
      strb_q   <= bus.PSTRB;
      wdata_q  <= bus.PWDATA;
      wcnt     <= WW'(WAIT_CYCLES);
      prdata_q <= (!bus.PWRITE && !err_in) ? mem[index_in] : '0;
    end else if (state == ACCESS) begin
      if (!bus.PSEL) begin
        state <= IDLE;
      end else if (wcnt != '0) begin
        wcnt <= wcnt - WW'(1);
      end else begin
        state <= IDLE;
        if (write_q && !err_q) begin
          for (int b = 0; b < SW; b++) begin
            if (strb_q[b]) mem[index_q][8*b +: 8] <= wdata_q[8*b +: 8];
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_apb4_slave_mem.sv
// Bench for apb4_slave_mem: three instances (WAIT_CYCLES 1, 3, 0) driven by directed
// and random transfers, checked by a queue-based scoreboard against a word-array model.
module tb_apb4_slave_mem;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int SW    = DW / 8;
  localparam int DEPTH = 16;
  localparam int ND    = 3;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [ND-1:0] psel, penable, pwrite, pready, pslverr;
  logic [AW-1:0] paddr  [ND];
  logic [DW-1:0] pwdata [ND];
  logic [DW-1:0] prdata [ND];
  logic [SW-1:0] pstrb  [ND];
  logic [0:0]    dbg_state [ND];

  for (genvar g = 0; g < ND; g++) begin : g_dut
    apb4_slave_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    assign bus.PSEL    = psel[g];
    assign bus.PENABLE = penable[g];
    assign bus.PWRITE  = pwrite[g];
    assign bus.PADDR   = paddr[g];
    assign bus.PWDATA  = pwdata[g];
    assign bus.PSTRB   = pstrb[g];
    assign pready[g]   = bus.PREADY;
    assign pslverr[g]  = bus.PSLVERR;
    assign prdata[g]   = bus.PRDATA;
    apb4_slave_mem #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH),
      .WAIT_CYCLES((g == 0) ? 1 : ((g == 1) ? 3 : 0))
    ) dut (
      .PCLK(clk), .PRESETn(rst_n), .bus(bus.slave), .dbg_state(dbg_state[g])
    );
  end

  // scoreboard state: {is_read, err, data}
  logic [DW+1:0] exp_q[$];
  logic [DW+1:0] exp_e;
  logic [DW-1:0] mem_m [ND][DEPTH];
  int checks = 0;
  int fails  = 0;

  function automatic int wait_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 3 : 0);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic clear_model();
    for (int d = 0; d < ND; d++)
      for (int i = 0; i < DEPTH; i++) mem_m[d][i] = '0;
  endtask

  // monitor: every completing transfer pops one expected response
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < ND; d++) begin
        if (psel[d] && penable[d] && pready[d]) begin
          if (exp_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_completion: dut %0d completed with nothing expected", d);
          end else begin
            exp_e = exp_q.pop_front();
            check($sformatf("pslverr_d%0d", d), 64'(pslverr[d]), 64'(exp_e[DW]));
            if (exp_e[DW+1]) check($sformatf("prdata_d%0d", d), 64'(prdata[d]), 64'(exp_e[DW-1:0]));
          end
        end
      end
    end
  end

  task automatic idle_all();
    @(posedge clk); #2;
    for (int k = 0; k < ND; k++) begin psel[k] = 1'b0; penable[k] = 1'b0; end
  endtask

  // driver: one transfer on dut d; abort_after >= 0 drops PSEL after that many access cycles
  task automatic xfer(input int d, input bit wr, input logic [AW-1:0] addr,
                      input logic [DW-1:0] data, input logic [SW-1:0] strb, input int abort_after);
    int n;
    bit done;
    bit err;
    logic [DW-1:0] rd;
    err = (addr % SW != 0) || (addr >= DEPTH * SW);
    @(posedge clk); #2;
    for (int k = 0; k < ND; k++) begin psel[k] = 1'b0; penable[k] = 1'b0; end
    psel[d] = 1'b1; pwrite[d] = wr; paddr[d] = addr; pwdata[d] = data; pstrb[d] = strb;
    if (abort_after < 0) begin
      rd = '0;
      if (!err && !wr) rd = mem_m[d][addr / SW];
      if (!err && wr)
        for (int b = 0; b < SW; b++)
          if (strb[b]) mem_m[d][addr / SW][8*b +: 8] = data[8*b +: 8];
      exp_q.push_back({~wr, err, rd});
    end
    @(posedge clk); #2;
    penable[d] = 1'b1;
    paddr[d] = $urandom; pwdata[d] = $urandom; pstrb[d] = 4'($urandom); pwrite[d] = ~wr;
    n = 2;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (abort_after >= 0 && n - 1 == abort_after) begin
        check("abort_pready", 64'(pready[d]), 64'd0);
        @(posedge clk); #2;
        psel[d] = 1'b0; penable[d] = 1'b0;
        @(negedge clk);
        check("abort_pready_drop", 64'(pready[d]), 64'd0);
        done = 1'b1;
      end else if (pready[d]) begin
        check($sformatf("latency_d%0d", d), 64'(n), 64'(2 + wait_of(d)));
        done = 1'b1;
      end else if (n > 40) begin
        checks++;
        fails++;
        $display("FAIL timeout: dut %0d no PREADY after %0d cycles", d, n);
        done = 1'b1;
      end else begin
        @(posedge clk); #2;
        n++;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    psel = '0; penable = '0; pwrite = '0;
    for (int k = 0; k < ND; k++) begin paddr[k] = '0; pwdata[k] = '0; pstrb[k] = '0; end
    clear_model();
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      check("reset_pready", 64'(pready[d]), 64'd0);
      check("reset_pslverr", 64'(pslverr[d]), 64'd0);
      check("reset_prdata", 64'(prdata[d]), 64'd0);
      check("reset_state", 64'(dbg_state[d]), 64'd0);
    end
    @(posedge clk); #2;
    rst_n = 1'b1;

    // first read after reset
    xfer(0, 1'b0, 32'h0, '0, 4'h0, -1);

    // byte-strobe merge, then PRDATA hold while idle
    xfer(0, 1'b1, 32'h8, 32'hDEADBEEF, 4'hF, -1);
    xfer(0, 1'b1, 32'h8, 32'h000000AA, 4'h1, -1);
    xfer(0, 1'b0, 32'h8, '0, 4'h0, -1);
    idle_all();
    @(negedge clk);
    check("prdata_hold", 64'(prdata[0]), 64'hDEADBEAA);
    @(negedge clk);
    check("prdata_hold2", 64'(prdata[0]), 64'hDEADBEAA);

    // error responses
    xfer(0, 1'b1, 32'h4, 32'hCAFE0004, 4'hF, -1);
    xfer(0, 1'b0, 32'h40, '0, 4'hF, -1);
    xfer(0, 1'b1, 32'h6, 32'h11, 4'hF, -1);
    xfer(0, 1'b0, 32'h4, '0, 4'h0, -1);
    xfer(0, 1'b1, 32'h4, 32'h55555555, 4'h0, -1);
    xfer(0, 1'b0, 32'h4, '0, 4'h0, -1);

    // abort on the three-wait instance
    xfer(1, 1'b1, 32'hC, 32'h55, 4'hF, 2);
    xfer(1, 1'b0, 32'hC, '0, 4'h0, -1);

    // reset in the middle of a read
    xfer(0, 1'b1, 32'h0, 32'h12345678, 4'hF, -1);
    @(posedge clk); #2;
    for (int k = 0; k < ND; k++) begin psel[k] = 1'b0; penable[k] = 1'b0; end
    psel[0] = 1'b1; pwrite[0] = 1'b0; paddr[0] = 32'h0;
    @(posedge clk); #2;
    penable[0] = 1'b1;
    @(negedge clk);
    check("mid_read_prdata", 64'(prdata[0]), 64'h12345678);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_pready", 64'(pready[0]), 64'd0);
    check("async_rst_pslverr", 64'(pslverr[0]), 64'd0);
    check("async_rst_prdata", 64'(prdata[0]), 64'd0);
    psel[0] = 1'b0; penable[0] = 1'b0;
    clear_model();
    @(posedge clk); #2;
    rst_n = 1'b1;
    xfer(0, 1'b0, 32'h0, '0, 4'h0, -1);

    // zero-wait instance, back-to-back
    xfer(2, 1'b1, 32'h4, 32'hA5A5_0004, 4'hF, -1);
    xfer(2, 1'b0, 32'h4, '0, 4'h0, -1);
    xfer(2, 1'b1, 32'h3C, 32'h5A5A_003C, 4'hF, -1);
    xfer(2, 1'b0, 32'h3C, '0, 4'h0, -1);

    // random traffic
    for (int t = 0; t < 80; t++) begin
      int d;
      int ab;
      d = $urandom_range(0, ND - 1);
      ab = -1;
      if (d == 1 && $urandom_range(0, 5) == 0) ab = $urandom_range(1, 2);
      xfer(d, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 71)), $urandom, 4'($urandom), ab);
      if ($urandom_range(0, 3) == 0) idle_all();
    end

    idle_all();
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
